// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: the fetch state encoding,
// the instruction fields fetch needs to recognise, and PC step constants.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [5:0]  OPC_RTYPE     = 6'b000000;
    localparam logic [5:0]  FUNCT_SYSCALL = 6'b001100;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam logic [31:0] PC_INCR       = 32'd4;
    localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

    // True when the opcode/funct pair encodes a syscall.
    function automatic logic is_syscall(input logic [5:0] opc, input logic [5:0] funct);
        return (opc == OPC_RTYPE) && (funct == FUNCT_SYSCALL);
    endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Next-PC selection: jump target, taken branch target, or sequential pc+4.
// Only the low 26 instruction bits are consumed, so only those are passed in.
module next_pc
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] npc
);

    logic [31:0] branch_off_s;
    logic [31:0] raw_s;

    // Select the target; jump wins over branch, result forced word-aligned.
    always_comb begin
        branch_off_s = {{14{instr[15]}}, instr[15:0], 2'b00};
        raw_s        = pc_plus4;
        if (jump) begin
            raw_s = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            raw_s = pc_plus4 + branch_off_s;
        end else begin
            raw_s = pc_plus4;
        end
        npc = raw_s & WORD_MASK;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: BOOT/RUN/HALT sequencing, PC register, commit
// qualification and committed-instruction counter. Instruction memory is
// read combinationally at the current PC.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic        HALT_ON_SYSCALL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        halted,
    output logic [31:0] instr_count
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & WORD_MASK;

    fetch_state_t state_r;
    logic [31:0]  pc_r;
    logic [31:0]  count_r;
    logic         halted_r;
    logic [31:0]  npc_s;
    logic         halt_now_s;

    assign pc          = pc_r;
    assign imem_addr   = pc_r;
    assign pc_plus4    = pc_r + PC_INCR;
    assign opcode      = instr[31:26];
    assign halted      = halted_r;
    assign instr_count = count_r;

    // Present the fetched word only while running; otherwise issue a NOP.
    always_comb begin
        if (state_r == ST_RUN) begin
            instr       = imem_rdata;
            instr_valid = ~stall;
        end else begin
            instr       = NOP_INSTR;
            instr_valid = 1'b0;
        end
    end

    // A committing syscall stops fetch when halting is enabled.
    always_comb begin
        if (HALT_ON_SYSCALL && instr_valid) begin
            halt_now_s = is_syscall(instr[31:26], instr[5:0]);
        end else begin
            halt_now_s = 1'b0;
        end
    end

    next_pc u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr[25:0]),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .npc      (npc_s)
    );

    // Fetch state machine with PC, counter and halt flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_BOOT;
            pc_r     <= RESET_PC_ALIGNED;
            count_r  <= 32'd0;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r  <= ST_RUN;
                    halted_r <= 1'b0;
                end
                ST_RUN: begin
                    if (!stall) begin
                        count_r <= count_r + 32'd1;
                        if (halt_now_s) begin
                            state_r  <= ST_HALT;
                            halted_r <= 1'b1;
                        end else begin
                            pc_r <= npc_s;
                        end
                    end
                end
                ST_HALT: begin
                    state_r  <= ST_HALT;
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_BOOT;
                    pc_r     <= RESET_PC_ALIGNED;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a per-cycle vector table on a DUT
// reset to 0, plus a short sequence on a second DUT placed high in memory
// with syscall halting disabled.
module tb_instr_fetch;

    localparam logic [31:0] A1   = 32'h2008_0001;
    localparam logic [31:0] A2   = 32'h2009_0002;
    localparam logic [31:0] A3   = 32'h200A_0003;
    localparam logic [31:0] A4   = 32'h200B_0004;
    localparam logic [31:0] A5   = 32'h200C_0005;
    localparam logic [31:0] A6   = 32'h200D_0006;
    localparam logic [31:0] BEQ  = 32'h1000_FFFE;
    localparam logic [31:0] JMP  = 32'h0800_0100;
    localparam logic [31:0] SYS  = 32'h0000_000C;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        branch;
        logic        zero;
        logic        jump;
        logic [31:0] rdata;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        exp_halted;
        logic [31:0] exp_count;
        logic [31:0] exp_instr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, stall, branch, zero, jump;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr, instr, pc, pc_plus4, instr_count;
    logic [5:0]  opcode;
    logic        instr_valid, halted;

    logic        h_rst, h_stall, h_branch, h_zero, h_jump;
    logic [31:0] h_rdata;
    logic [31:0] h_imem_addr, h_instr, h_pc, h_pc_plus4, h_count;
    logic [5:0]  h_opcode;
    logic        h_valid, h_halted;

    int checks = 0;
    int errors = 0;

    vec_t vecs[24];
    vec_t sb_q[$];

    always #5 clk = ~clk;

    instr_fetch u_dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .zero(zero),
        .jump(jump), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
        .instr(instr), .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .halted(halted), .instr_count(instr_count)
    );

    instr_fetch #(.RESET_PC(32'h4000_0020), .HALT_ON_SYSCALL(1'b0)) u_hi (
        .clk(clk), .rst(h_rst), .stall(h_stall), .branch(h_branch), .zero(h_zero),
        .jump(h_jump), .imem_rdata(h_rdata), .imem_addr(h_imem_addr),
        .instr(h_instr), .opcode(h_opcode), .pc(h_pc), .pc_plus4(h_pc_plus4),
        .instr_valid(h_valid), .halted(h_halted), .instr_count(h_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic b, input logic z,
                                input logic j, input logic [31:0] rd, input logic [31:0] epc,
                                input logic ev, input logic eh, input logic [31:0] ec,
                                input logic [31:0] ei);
        vec_t v;
        v.rst = r; v.stall = s; v.branch = b; v.zero = z; v.jump = j; v.rdata = rd;
        v.exp_pc = epc; v.exp_valid = ev; v.exp_halted = eh;
        v.exp_count = ec; v.exp_instr = ei;
        return v;
    endfunction

    initial begin
        vec_t e;
        rst = 1'b1; stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; imem_rdata = A1;
        h_rst = 1'b1; h_stall = 1'b0; h_branch = 1'b0; h_zero = 1'b0; h_jump = 1'b0; h_rdata = NOP;

        //            rst  stl  br   z    j    rdata  pc            v    h    cnt    instr
        vecs[0]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0, A1,  32'h0000_0000,1'b0,1'b0,32'd0, NOP);
        vecs[1]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0, A1,  32'h0000_0000,1'b0,1'b0,32'd0, NOP);
        vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0, A1,  32'h0000_0000,1'b1,1'b0,32'd0, A1);
        vecs[3]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0, A2,  32'h0000_0004,1'b1,1'b0,32'd1, A2);
        vecs[4]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0, A3,  32'h0000_0008,1'b0,1'b0,32'd2, A3);
        vecs[5]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0, A3,  32'h0000_0008,1'b0,1'b0,32'd2, A3);
        vecs[6]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0, A3,  32'h0000_0008,1'b0,1'b0,32'd2, A3);
        vecs[7]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0, A3,  32'h0000_0008,1'b1,1'b0,32'd2, A3);
        vecs[8]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0, A4,  32'h0000_000C,1'b1,1'b0,32'd3, A4);
        vecs[9]  = mk(1'b0,1'b0,1'b1,1'b1,1'b0, BEQ, 32'h0000_0010,1'b1,1'b0,32'd4, BEQ);
        vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, A4,  32'h0000_000C,1'b1,1'b0,32'd5, A4);
        vecs[11] = mk(1'b0,1'b0,1'b1,1'b0,1'b0, BEQ, 32'h0000_0010,1'b1,1'b0,32'd6, BEQ);
        vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, A5,  32'h0000_0014,1'b1,1'b0,32'd7, A5);
        vecs[13] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, SYS, 32'h0000_0018,1'b1,1'b0,32'd8, SYS);
        vecs[14] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, A6,  32'h0000_0018,1'b0,1'b1,32'd9, NOP);
        vecs[15] = mk(1'b0,1'b0,1'b1,1'b1,1'b1, JMP, 32'h0000_0018,1'b0,1'b1,32'd9, NOP);
        vecs[16] = mk(1'b1,1'b0,1'b0,1'b0,1'b0, A1,  32'h0000_0000,1'b0,1'b0,32'd0, NOP);
        vecs[17] = mk(1'b0,1'b0,1'b1,1'b1,1'b0, BEQ, 32'h0000_0000,1'b0,1'b0,32'd0, NOP);
        vecs[18] = mk(1'b0,1'b0,1'b1,1'b1,1'b0, BEQ, 32'h0000_0000,1'b1,1'b0,32'd0, BEQ);
        vecs[19] = mk(1'b0,1'b1,1'b0,1'b0,1'b0, A1,  32'hFFFF_FFFC,1'b0,1'b0,32'd1, A1);
        vecs[20] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, A1,  32'hFFFF_FFFC,1'b1,1'b0,32'd1, A1);
        vecs[21] = mk(1'b0,1'b0,1'b1,1'b1,1'b0, BEQ, 32'h0000_0000,1'b1,1'b0,32'd2, BEQ);
        vecs[22] = mk(1'b1,1'b1,1'b0,1'b0,1'b0, A2,  32'h0000_0000,1'b0,1'b0,32'd0, NOP);
        vecs[23] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, A2,  32'h0000_0000,1'b0,1'b0,32'd0, NOP);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; stall = vecs[i].stall; branch = vecs[i].branch;
            zero = vecs[i].zero; jump = vecs[i].jump; imem_rdata = vecs[i].rdata;
            sb_q.push_back(vecs[i]);
            #1;
            e = sb_q.pop_front();
            chk($sformatf("v%0d pc", i), pc, e.exp_pc);
            chk($sformatf("v%0d imem_addr", i), imem_addr, e.exp_pc);
            chk($sformatf("v%0d pc_plus4", i), pc_plus4, e.exp_pc + 32'd4);
            chk($sformatf("v%0d instr", i), instr, e.exp_instr);
            chk($sformatf("v%0d opcode", i), {26'd0, opcode}, {26'd0, e.exp_instr[31:26]});
            chk($sformatf("v%0d valid", i), {31'd0, instr_valid}, {31'd0, e.exp_valid});
            chk($sformatf("v%0d halted", i), {31'd0, halted}, {31'd0, e.exp_halted});
            chk($sformatf("v%0d count", i), instr_count, e.exp_count);
        end

        // High-memory DUT: jump beats branch, syscall commits without halting.
        @(negedge clk);
        h_rst = 1'b1;
        #1;
        chk("hi reset pc", h_pc, 32'h4000_0020);
        @(negedge clk);
        h_rst = 1'b0;
        #1;
        chk("hi boot valid", {31'd0, h_valid}, 32'd0);
        @(negedge clk);
        h_rdata = JMP; h_jump = 1'b1; h_branch = 1'b1; h_zero = 1'b1;
        #1;
        chk("hi jump valid", {31'd0, h_valid}, 32'd1);
        chk("hi jump opcode", {26'd0, h_opcode}, 32'd2);
        chk("hi jump pc", h_pc, 32'h4000_0020);
        @(negedge clk);
        h_rdata = SYS; h_jump = 1'b0; h_branch = 1'b0; h_zero = 1'b0;
        #1;
        chk("hi jump target", h_pc, 32'h4000_0400);
        chk("hi count after jump", h_count, 32'd1);
        @(negedge clk);
        h_rdata = A1;
        #1;
        chk("hi syscall no halt pc", h_pc, 32'h4000_0404);
        chk("hi syscall no halt flag", {31'd0, h_halted}, 32'd0);
        chk("hi syscall counted", h_count, 32'd2);
        chk("hi still valid", {31'd0, h_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset (word-aligned).
REQ-002 SHALL have parameter HALT_ON_SYSCALL, default 1, meaning 1 enables halt on syscall (opcode 0, funct 6'b001100).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port stall  input  1  hold PC and suppress commit this cycle.
REQ-006 SHALL have port branch  input  1  Branch from main control.
REQ-007 SHALL have port zero  input  1  ALU zero flag.
REQ-008 SHALL have port jump  input  1  jump from main control.
REQ-009 SHALL have port imem_rdata  input  32  combinational instruction memory read data.
REQ-010 SHALL have port imem_addr  output  32  instruction memory byte address (equals pc).
REQ-011 SHALL have port instr  output  32  current instruction to decode.
REQ-012 SHALL have port opcode  output  6  instr[31:26], to main control.
REQ-013 SHALL have port pc  output  32  current PC.
REQ-014 SHALL have port pc_plus4  output  32  pc + 4, to datapath (link/branch base).
REQ-015 SHALL have port instr_valid  output  1  instr is architecturally committing this cycle.
REQ-016 SHALL have port halted  output  1  fetch stopped in HALT state.
REQ-017 SHALL have port instr_count  output  32  count of committed instructions.

Function
REQ-018 SHALL implement states BOOT, RUN, HALT in a registered state register.
REQ-019 SHALL enter BOOT on reset; BOOT SHALL last exactly one cycle, then go to RUN.
REQ-020 In BOOT and HALT, instr SHALL be 32'h0 (NOP), instr_valid 0, PC held.
REQ-021 In RUN with stall=0, instr SHALL equal imem_rdata, instr_valid 1, PC updated at next edge.
REQ-022 In RUN with stall=1, instr SHALL equal imem_rdata, instr_valid 0, PC, state and instr_count held.
REQ-023 Next PC SHALL be: jump=1 -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch&zero -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-024 jump SHALL take priority over branch when both asserted.
REQ-025 All PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 SHALL wrap to 0 with no flag.
REQ-026 pc[1:0] SHALL always be 2'b00; low two bits of any target are forced to zero.
REQ-027 With HALT_ON_SYSCALL=1, a committing syscall in RUN SHALL be counted, PC SHALL stay at the syscall, state SHALL go to HALT.
REQ-028 HALT SHALL be left only by reset; halted=1 exactly while in HALT.
REQ-029 instr_count SHALL increment by 1 on each edge where instr_valid=1, wrapping at 2^32.
REQ-030 opcode SHALL equal instr[31:26] in every state (6'b0 when NOP forced).
REQ-031 imem_addr SHALL equal pc combinationally.

Reset
REQ-032 On rst=1, asynchronously: pc=RESET_PC, state=BOOT, instr_count=0, halted=0, instr_valid=0.
REQ-033 Reset asserted mid-operation (including during stall or HALT) SHALL override all other inputs immediately.
REQ-034 After rst deasserts, first instr_valid=1 SHALL occur on the second rising edge window (one BOOT cycle).

Structure
REQ-035 Shared package SHALL hold state encoding (BOOT/RUN/HALT), OPC_RTYPE, FUNCT_SYSCALL, NOP_INSTR, and PC_INCR=4.
REQ-036 Next-PC selection SHALL be a sub-module named next_pc (combinational: pc_plus4, instr, branch, zero, jump -> next PC).

Verification
REQ-037 Reset then sequential ROM, no branches -> pc 0,0,4,8,C on successive cycles; instr_count 3 after 4 cycles.
REQ-038 At pc=0x10 instr beq with imm=0xFFFE, branch=1, zero=1 -> next pc=0x0C; zero=0 -> next pc=0x14.
REQ-039 At pc=0x4000_0020 instr j with index 0x000_0100, jump=1 and branch=1, zero=1 -> next pc=0x4000_0400.
REQ-040 stall=1 for 3 cycles in RUN at pc=0x08 -> pc held at 0x08, instr_valid 0, instr_count unchanged; resumes to 0x0C.
REQ-041 syscall (32'h0000_000C) at pc=0x18 -> instr_count+1, halted=1 next cycle, pc stays 0x18, instr=0 thereafter.
REQ-042 rst pulsed mid-HALT and at pc=0xFFFF_FFFC run -> pc returns to RESET_PC asynchronously; un-reset wrap gives pc=0.
